// File: rtl/exc_sequencer.sv
// Exception/interrupt sequencer driving the CP0 Cause/Status/EPC write strobes and PC redirects.
// Optional build macro EXC_SEQUENCER_TIMER_EN adds an internal compare timer as an extra interrupt source.
module exc_sequencer #(
  parameter int          N_IRQ       = 8,
  parameter logic [31:0] HANDLER_VEC = 32'h0000_0004,
  parameter logic [31:0] TIMER_CMP   = 32'd100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq,
  input  logic             instr_done,
  input  logic             syscall,
  input  logic             eret,
  input  logic             mtc0,
  input  logic [31:0]      status_in,
  input  logic [31:0]      epc_in,
  output logic             wcau,
  output logic             wsta,
  output logic             wepc,
  output logic             exc,
  output logic             inta,
  output logic [31:0]      cause_out,
  output logic             hold,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic             busy
);

  typedef enum logic [2:0] {IDLE, ENTER, VECTOR, RET, RETJ} state_t;

  state_t           state, state_next;
  logic [N_IRQ-1:0] sync1, sync2, sync_prev;
  logic [N_IRQ-1:0] pending, irq_rise, take, clr;
  logic [2:0]       take_idx, irq_idx;
  logic [4:0]       code;
  logic             src_irq, src_timer;
  logic             take_timer, timer_bit;
  logic             entry_commit;
  logic [7:0]       pend8;
  logic             unused_bits;

  assign unused_bits = ^{status_in[31:N_IRQ+1], TIMER_CMP};

  // Two-flop synchronizer plus one history flop for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1     <= '0;
      sync2     <= '0;
      sync_prev <= '0;
    end else begin
      sync1     <= irq;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  assign irq_rise     = sync2 & ~sync_prev;
  assign take         = pending & status_in[N_IRQ:1] & {N_IRQ{status_in[0]}};
  assign entry_commit = (state == ENTER) && !mtc0;

  always_comb begin
    take_idx = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (take[i]) take_idx = 3'(i);
    end
  end

  always_comb begin
    clr = '0;
    if (entry_commit && src_irq) begin
      for (int i = 0; i < N_IRQ; i++) begin
        if (irq_idx == 3'(i)) clr[i] = 1'b1;
      end
    end
  end

  // A new edge in the same cycle as the clear keeps the line pending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pending <= '0;
    else        pending <= (pending & ~clr) | irq_rise;
  end

  always_comb begin
    pend8 = '0;
    pend8[N_IRQ-1:0] = pending;
  end

`ifdef EXC_SEQUENCER_TIMER_EN
  logic [31:0] timer_count;
  logic        timer_pending;
  logic        timer_wrap;

  assign timer_wrap = (timer_count == TIMER_CMP - 32'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer_count   <= '0;
      timer_pending <= 1'b0;
    end else begin
      timer_count   <= timer_wrap ? 32'd0 : timer_count + 32'd1;
      timer_pending <= timer_wrap | (timer_pending & ~(entry_commit & src_timer));
    end
  end

  assign take_timer = timer_pending & status_in[9] & status_in[0];
  assign timer_bit  = timer_pending;
`else
  assign take_timer = 1'b0;
  assign timer_bit  = 1'b0;
`endif

  // Capture the winning source at the boundary so ENTER knows what to report and clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      code      <= '0;
      src_irq   <= 1'b0;
      src_timer <= 1'b0;
      irq_idx   <= '0;
    end else if (state == IDLE && instr_done && !eret) begin
      if (syscall) begin
        code      <= 5'd8;
        src_irq   <= 1'b0;
        src_timer <= 1'b0;
      end else if (take_timer) begin
        code      <= 5'd0;
        src_irq   <= 1'b0;
        src_timer <= 1'b1;
      end else if (|take) begin
        code      <= 5'd0;
        src_irq   <= 1'b1;
        src_timer <= 1'b0;
        irq_idx   <= take_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (instr_done) begin
          if (eret)                     state_next = RET;
          else if (syscall)             state_next = ENTER;
          else if (take_timer || |take) state_next = ENTER;
        end
      end
      ENTER:   state_next = mtc0 ? ENTER : VECTOR;
      VECTOR:  state_next = IDLE;
      RET:     state_next = mtc0 ? RET : RETJ;
      RETJ:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    wcau        = 1'b0;
    wsta        = 1'b0;
    wepc        = 1'b0;
    exc         = 1'b0;
    inta        = 1'b0;
    cause_out   = '0;
    hold        = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    busy        = (state != IDLE);
    unique case (state)
      ENTER: begin
        hold      = 1'b1;
        cause_out = {15'b0, timer_bit, pend8, 1'b0, code, 2'b00};
        if (!mtc0) begin
          wcau = 1'b1;
          wsta = 1'b1;
          wepc = 1'b1;
          inta = src_irq | src_timer;
        end
      end
      VECTOR: begin
        hold        = 1'b1;
        redirect    = 1'b1;
        redirect_pc = HANDLER_VEC;
      end
      RET: begin
        hold = 1'b1;
        if (!mtc0) begin
          wsta = 1'b1;
          exc  = 1'b1;
        end
      end
      RETJ: begin
        hold        = 1'b1;
        redirect    = 1'b1;
        redirect_pc = epc_in;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_exc_sequencer.sv
// Directed self-checking bench for exc_sequencer: interrupt/syscall entry, eret return,
// mtc0 stalls, IE masking and asynchronous reset mid-sequence.
module tb_exc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  irq;
  logic        instr_done, syscall, eret, mtc0;
  logic [31:0] status_in, epc_in;
  logic        wcau, wsta, wepc, exc, inta, hold, redirect, busy;
  logic [31:0] cause_out, redirect_pc;

  int n_checks = 0;
  int n_fail   = 0;

  exc_sequencer #(.N_IRQ(8), .HANDLER_VEC(32'h0000_0004), .TIMER_CMP(32'd100000)) dut (
    .clk(clk), .reset(reset), .irq(irq), .instr_done(instr_done), .syscall(syscall),
    .eret(eret), .mtc0(mtc0), .status_in(status_in), .epc_in(epc_in),
    .wcau(wcau), .wsta(wsta), .wepc(wepc), .exc(exc), .inta(inta), .cause_out(cause_out),
    .hold(hold), .redirect(redirect), .redirect_pc(redirect_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic done, input logic sc, input logic er, input logic m);
    instr_done = done;
    syscall    = sc;
    eret       = er;
    mtc0       = m;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Pulse one irq line for a cycle, then give the synchronizer time to set pending.
  task automatic pulseIrq(input int idx);
    irq[idx] = 1'b1;
    tick();
    irq[idx] = 1'b0;
    repeat (4) tick();
  endtask

  // Strobe bundle packed as {wcau,wsta,wepc,exc,inta,hold,redirect,busy}.
  function automatic logic [31:0] strobes();
    return {24'b0, wcau, wsta, wepc, exc, inta, hold, redirect, busy};
  endfunction

  initial begin
    reset     = 1'b0;
    irq       = '0;
    status_in = 32'h0;
    epc_in    = 32'h0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    checkOutput("reset_strobes", strobes(), 32'h00);
    checkOutput("reset_cause", cause_out, 32'h0);
    checkOutput("reset_rpc", redirect_pc, 32'h0);
    reset = 1'b1;
    tick();

    // Interrupt entry on irq[0].
    status_in = 32'h0000_0003;
    pulseIrq(0);
    checkOutput("irq0_idle", strobes(), 32'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("irq0_enter", strobes(), 32'b1110_1101);
    checkOutput("irq0_cause", cause_out, 32'h0000_0100);
    tick();
    checkOutput("irq0_vector", strobes(), 32'b0000_0111);
    checkOutput("irq0_vec_pc", redirect_pc, 32'h0000_0004);
    tick();
    checkOutput("irq0_back_idle", strobes(), 32'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("irq0_cleared", strobes(), 32'h00);

    // Syscall beats a pending, enabled irq[2]; irq[2] is then taken next boundary.
    status_in = 32'h0000_01FF;
    pulseIrq(2);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("sys_enter", strobes(), 32'b1110_0101);
    checkOutput("sys_cause", cause_out, 32'h0000_0420);
    tick();
    checkOutput("sys_vector", strobes(), 32'b0000_0111);
    tick();
    checkOutput("sys_idle", strobes(), 32'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("irq2_enter", strobes(), 32'b1110_1101);
    checkOutput("irq2_cause", cause_out, 32'h0000_0400);
    tick();
    tick();

    // eret return; a retire signalled while busy must be ignored.
    epc_in = 32'h0000_0120;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("ret_state", strobes(), 32'b0101_0101);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("retj_state", strobes(), 32'b0000_0111);
    checkOutput("retj_pc", redirect_pc, 32'h0000_0120);
    tick();
    checkOutput("ret_idle", strobes(), 32'h00);

    // mtc0 held for three cycles stalls ENTER with no strobes.
    pulseIrq(3);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput($sformatf("mtc0_stall%0d", i), strobes(), 32'b0000_0101);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("mtc0_commit", strobes(), 32'b1110_1101);
    checkOutput("mtc0_cause", cause_out, 32'h0000_0800);
    tick();
    checkOutput("mtc0_vector", strobes(), 32'b0000_0111);
    tick();

    // IE=0 blocks irq[1]; eret restores IE and the next boundary takes it.
    status_in = 32'h0000_01FE;
    pulseIrq(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("ie0_no_entry", strobes(), 32'h00);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("ie0_ret", strobes(), 32'b0101_0101);
    tick();
    checkOutput("ie0_retj", redirect_pc, 32'h0000_0120);
    tick();
    status_in = 32'h0000_01FF;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("ie1_enter", strobes(), 32'b1110_1101);
    checkOutput("ie1_cause", cause_out, 32'h0000_0200);
    tick();
    tick();

    // Reset asserted while in VECTOR.
    pulseIrq(4);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_enter", cause_out, 32'h0000_1000);
    tick();
    reset = 1'b0;
    #1;
    checkOutput("rst_async", strobes(), 32'h00);
    checkOutput("rst_async_pc", redirect_pc, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("rst_hold%0d", i), strobes(), 32'h00);
    end
    reset = 1'b1;
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_pending_clear", strobes(), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
